// File: rtl/reg_content_reader.sv
// Register content reader: turns a software request toggle into one fabric
// register read and holds the result on content_out, echoing the toggle on ack_tgl.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   cmd_addr            register address, stable before the toggle edge
//   cmd_req_tgl         request toggle; any edge is a new request
//   rf_rd_en/rf_rd_addr read strobe (one cycle) and held read address
//   rf_rd_data/valid    read return from the register file
//   content_out         held read result (or TIMEOUT_WORD on timeout)
//   ack_tgl             accepted toggle value, set once content_out is valid
//   busy                high from accept until the request completes
//   err_timeout         last request timed out; cleared on next accept
module reg_content_reader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_WORD = DATA_W'(32'hDEADBEEF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_req_tgl,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic              rf_rd_valid,
    output logic [DATA_W-1:0] content_out,
    output logic              ack_tgl,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   last_req;
    logic [15:0]            timer_q;
    logic                   pending;
    logic                   accept;
    logic                   rd_ok;
    logic                   tmo;
    logic                   tick;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign pending = (req_s != last_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmd_req_tgl};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid is checked before the timeout so a coincident return wins.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rd_ok   = 1'b0;
        tmo     = 1'b0;
        tick    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pending) begin
                    accept  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rf_rd_valid) begin
                    rd_ok   = 1'b1;
                    state_d = S_DONE;
                end else if (timer_q >= TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tick = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_req    <= 1'b0;
            timer_q     <= '0;
            rf_rd_en    <= 1'b0;
            rf_rd_addr  <= '0;
            content_out <= '0;
            ack_tgl     <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // High only during the ISSUE cycle.
            rf_rd_en <= accept;
            if (accept) begin
                rf_rd_addr  <= cmd_addr;
                last_req    <= req_s;
                busy        <= 1'b1;
                err_timeout <= 1'b0;
                timer_q     <= '0;
            end
            if (tick && (timer_q != 16'hFFFF)) begin
                timer_q <= timer_q + 16'd1;
            end
            if (rd_ok) begin
                content_out <= rf_rd_data;
            end
            if (tmo) begin
                content_out <= TIMEOUT_WORD;
                err_timeout <= 1'b1;
            end
            if (state_q == S_DONE) begin
                ack_tgl <= last_req;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_content_reader.sv
// Directed testbench for reg_content_reader.
// Each scenario task drives stimulus and checks results against hand-computed values.
module tb_reg_content_reader;

    logic        clk;
    logic        reset_n;
    logic [7:0]  cmd_addr;
    logic        cmd_req_tgl;
    logic        rf_rd_en;
    logic [7:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_rd_valid;
    logic [31:0] content_out;
    logic        ack_tgl;
    logic        busy;
    logic        err_timeout;

    int total;
    int bad;

    reg_content_reader #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .SYNC_STAGES (2),
        .TIMEOUT     (8),
        .TIMEOUT_WORD(32'hDEADBEEF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_addr   (cmd_addr),
        .cmd_req_tgl(cmd_req_tgl),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_rd_valid(rf_rd_valid),
        .content_out(content_out),
        .ack_tgl    (ack_tgl),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the read strobe; n = edges taken.
    task automatic wait_rd_en(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (rf_rd_en) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    // Called while in ISSUE; data is sampled dly edges later.
    task automatic serve(input int dly, input logic [31:0] d);
        repeat (dly - 1) step();
        rf_rd_valid = 1'b1;
        rf_rd_data  = d;
        step();
        rf_rd_valid = 1'b0;
        rf_rd_data  = '0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        cmd_addr    = '0;
        cmd_req_tgl = 1'b0;
        rf_rd_data  = '0;
        rf_rd_valid = 1'b0;
        repeat (3) step();
        total++;
        if ({rf_rd_en, rf_rd_addr, content_out, ack_tgl, busy, err_timeout}
            !== 44'd0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b addr=%h c=%h ack=%b busy=%b err=%b want all 0",
                     rf_rd_en, rf_rd_addr, content_out, ack_tgl, busy, err_timeout);
        end
        reset_n = 1'b1;
        repeat (5) step();
        total++;
        if (rf_rd_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got en=%b busy=%b want 0 0", rf_rd_en, busy);
        end
    endtask

    task automatic test_basic_read();
        int n;
        bit ok;
        cmd_addr    = 8'h05;
        cmd_req_tgl = 1'b1;
        wait_rd_en(n, ok);
        total++;
        if (!ok || n != 3) begin
            bad++;
            $display("FAIL rd_en_latency got ok=%b edges=%0d want 1 3", ok, n);
        end
        total++;
        if (rf_rd_addr !== 8'h05 || busy !== 1'b1) begin
            bad++;
            $display("FAIL accept got addr=%h busy=%b want 05 1", rf_rd_addr, busy);
        end
        step();
        total++;
        if (rf_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL rd_en_one_cycle got %b want 0", rf_rd_en);
        end
        rf_rd_valid = 1'b1;
        rf_rd_data  = 32'h1234_5678;
        step();
        rf_rd_valid = 1'b0;
        rf_rd_data  = '0;
        total++;
        if (content_out !== 32'h1234_5678 || ack_tgl !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL content_first got c=%h ack=%b busy=%b want 12345678 0 1",
                     content_out, ack_tgl, busy);
        end
        step();
        total++;
        if (ack_tgl !== 1'b1 || busy !== 1'b0 || content_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL ack_first got ack=%b busy=%b c=%h want 1 0 12345678",
                     ack_tgl, busy, content_out);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        cmd_addr    = 8'hA0;
        cmd_req_tgl = 1'b0;
        wait_rd_en(n, ok);
        total++;
        if (!ok || rf_rd_addr !== 8'hA0) begin
            bad++;
            $display("FAIL b2b_issue got ok=%b addr=%h want 1 a0", ok, rf_rd_addr);
        end
        serve(2, 32'hCAFE_0001);
        step();
        total++;
        if (content_out !== 32'hCAFE_0001 || ack_tgl !== 1'b0 || err_timeout !== 1'b0
            || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_result got c=%h ack=%b err=%b busy=%b want cafe0001 0 0 0",
                     content_out, ack_tgl, err_timeout, busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        cmd_addr    = 8'h10;
        cmd_req_tgl = 1'b1;
        wait_rd_en(n, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tmo_issue got ok=0 want 1");
        end
        repeat (8) step();
        total++;
        if (content_out !== 32'hCAFE_0001 || busy !== 1'b1 || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early got c=%h busy=%b err=%b want cafe0001 1 0",
                     content_out, busy, err_timeout);
        end
        step();
        total++;
        if (content_out !== 32'hDEADBEEF || err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL tmo_expire got c=%h err=%b want deadbeef 1",
                     content_out, err_timeout);
        end
        step();
        total++;
        if (ack_tgl !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL tmo_ack got ack=%b busy=%b want 1 0", ack_tgl, busy);
        end
        cmd_addr    = 8'h11;
        cmd_req_tgl = 1'b0;
        wait_rd_en(n, ok);
        total++;
        if (!ok || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_clear_on_accept got ok=%b err=%b want 1 0", ok, err_timeout);
        end
        serve(3, 32'hA5A5_0011);
        step();
        total++;
        if (content_out !== 32'hA5A5_0011 || err_timeout !== 1'b0 || ack_tgl !== 1'b0) begin
            bad++;
            $display("FAIL tmo_recover got c=%h err=%b ack=%b want a5a50011 0 0",
                     content_out, err_timeout, ack_tgl);
        end
    endtask

    task automatic test_coincide();
        int n;
        bit ok;
        cmd_addr    = 8'h20;
        cmd_req_tgl = 1'b1;
        wait_rd_en(n, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL coin_issue got ok=0 want 1");
        end
        serve(9, 32'h0000_00FF);
        total++;
        if (content_out !== 32'h0000_00FF || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL coin_valid_wins got c=%h err=%b want 000000ff 0",
                     content_out, err_timeout);
        end
        step();
        total++;
        if (ack_tgl !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL coin_ack got ack=%b busy=%b want 1 0", ack_tgl, busy);
        end
    endtask

    task automatic test_busy_toggle();
        int n;
        bit ok;
        cmd_addr    = 8'h30;
        cmd_req_tgl = 1'b0;
        wait_rd_en(n, ok);
        total++;
        if (!ok || rf_rd_addr !== 8'h30) begin
            bad++;
            $display("FAIL busy_first_issue got ok=%b addr=%h want 1 30", ok, rf_rd_addr);
        end
        // Extra request while busy, plus a spurious valid in ISSUE.
        cmd_addr    = 8'h3C;
        cmd_req_tgl = 1'b1;
        rf_rd_valid = 1'b1;
        rf_rd_data  = 32'hBAD0_BAD0;
        step();
        rf_rd_valid = 1'b0;
        rf_rd_data  = '0;
        total++;
        if (content_out !== 32'h0000_00FF || rf_rd_addr !== 8'h30) begin
            bad++;
            $display("FAIL issue_valid_ignored got c=%h addr=%h want 000000ff 30",
                     content_out, rf_rd_addr);
        end
        serve(2, 32'h1111_AAAA);
        total++;
        if (content_out !== 32'h1111_AAAA) begin
            bad++;
            $display("FAIL busy_first_data got c=%h want 1111aaaa", content_out);
        end
        wait_rd_en(n, ok);
        total++;
        if (!ok || rf_rd_addr !== 8'h3C) begin
            bad++;
            $display("FAIL busy_second_issue got ok=%b addr=%h want 1 3c", ok, rf_rd_addr);
        end
        serve(2, 32'h2222_BBBB);
        step();
        total++;
        if (content_out !== 32'h2222_BBBB || ack_tgl !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_second_done got c=%h ack=%b busy=%b want 2222bbbb 1 0",
                     content_out, ack_tgl, busy);
        end
        repeat (3) step();
        rf_rd_valid = 1'b1;
        rf_rd_data  = 32'h5555_5555;
        repeat (2) step();
        rf_rd_valid = 1'b0;
        rf_rd_data  = '0;
        step();
        total++;
        if (content_out !== 32'h2222_BBBB || busy !== 1'b0 || rf_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid_ignored got c=%h busy=%b en=%b want 2222bbbb 0 0",
                     content_out, busy, rf_rd_en);
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        int pulses;
        bit ok;
        cmd_addr    = 8'h40;
        cmd_req_tgl = 1'b0;
        wait_rd_en(n, ok);
        serve(2, 32'h4444_0040);
        step();
        total++;
        if (!ok || content_out !== 32'h4444_0040 || ack_tgl !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_read got ok=%b c=%h ack=%b want 1 44440040 0",
                     ok, content_out, ack_tgl);
        end
        cmd_addr    = 8'h41;
        cmd_req_tgl = 1'b1;
        wait_rd_en(n, ok);
        step();
        reset_n = 1'b0;
        #1;
        total++;
        if ({rf_rd_en, rf_rd_addr, content_out, ack_tgl, busy, err_timeout}
            !== 44'd0) begin
            bad++;
            $display("FAIL mid_reset got en=%b addr=%h c=%h ack=%b busy=%b err=%b want all 0",
                     rf_rd_en, rf_rd_addr, content_out, ack_tgl, busy, err_timeout);
        end
        repeat (3) step();
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rf_rd_en) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL post_reset_reads got %0d want 1", pulses);
        end
        total++;
        if (rf_rd_addr !== 8'h41 || ack_tgl !== 1'b1 || busy !== 1'b0
            || content_out !== 32'hDEADBEEF || err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_state got addr=%h ack=%b busy=%b c=%h err=%b want 41 1 0 deadbeef 1",
                     rf_rd_addr, ack_tgl, busy, content_out, err_timeout);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_read();
        test_back_to_back();
        test_timeout();
        test_coincide();
        test_busy_toggle();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
